sha256_stream_engine: RTL and testbench
=======================================

Name: sha256_stream_engine

Overview:
- Next-generation SHA-256 core with a runtime message length instead of a compile-time word count.
- Pads the message on the fly. Keeps a 16-entry rolling message schedule instead of a full 64-word W array and a full message buffer.
- Tolerates a configurable memory read latency.
- Optionally performs double SHA-256 (SHA256(SHA256(m))).
- Sits on the shared word-addressed memory port and writes its 8-word digest back to that memory.

Parameters:
- ADDR_W, 16, memory word-address width.
- LEN_W, 16, width of num_words; message length is 0..2^LEN_W-1 words.
- MEM_RD_LAT, 1, cycles from mem_addr presented to mem_read_data valid; legal range 1..4.
- DOUBLE_EN, 1, 1 = double_mode honoured; 0 = double_mode ignored and double-hash logic removed.

Ports:
- clk  in  1  system clock; also driven out as mem_clk.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- message_addr  in  ADDR_W  first message word address.
- output_addr  in  ADDR_W  first digest word address.
- num_words  in  LEN_W  message length in 32-bit words.
- double_mode  in  1  1 = double hash.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last digest write.
- mem_clk  out  1  = clk.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  word address.
- mem_write_data  out  32  write data.
- mem_read_data  in  32  read data.

Behaviour:
- Reset:
  - state = IDLE.
  - busy = 0, done = 0, mem_we = 0, mem_addr = 0, mem_write_data = 0.
  - Reset mid-operation aborts immediately; no further memory writes occur.
- Start acceptance:
  - start in IDLE latches message_addr, output_addr, num_words (L) and double_mode (forced 0 if DOUBLE_EN = 0).
  - H0..H7 are loaded with the SHA-256 IV.
  - start while busy is ignored.
- Padding (word-granular):
  - Block count NB = (L+2)/16 + 1 (integer division).
  - Word index n in 0..16*NB-1:
    - n < L: memory word at message_addr+n.
    - n == L: 32'h80000000.
    - n == 16*NB-1: L*32 (bit length, low 32 bits).
    - all other n: 0; this includes n == 16*NB-2, the upper length word.
  - L = 0 yields one block.
  - Address arithmetic wraps modulo 2^ADDR_W.
- State machine:
  - IDLE -> FETCH on accepted start.
  - FETCH:
    - Loads the 16 block words into the schedule window.
    - A memory word costs 1+MEM_RD_LAT cycles; mem_addr is held until capture.
    - A padding word costs 1 cycle.
    - After word 15 -> COMPUTE.
  - COMPUTE:
    - Exactly 64 cycles, one round per cycle; a..h are initialised from H on entry.
    - Round t<16 uses window word t.
    - Round t>=16 uses Wt = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16], computed from the window and shifted in the same cycle.
    - All additions are mod 2^32.
  - ADD: 1 cycle, Hi += working variable; then:
    - more blocks remain -> FETCH;
    - else double pass pending -> SECOND;
    - else -> WRITE.
  - SECOND:
    - 1 cycle; the schedule window is loaded with the second-pass block:
      - words 0..7 = current H0..H7;
      - word 8 = 32'h80000000;
      - words 9..14 = 0;
      - word 15 = 256.
    - H is reloaded with the IV; then -> COMPUTE.
    - No memory read occurs.
  - WRITE:
    - 8 consecutive cycles with mem_we = 1.
    - mem_addr = output_addr+k, mem_write_data = Hk, for k = 0..7.
  - DONE: done = 1 for one cycle, busy = 0, mem_we = 0; -> IDLE.
- Memory interface rules:
  - mem_we is never high outside WRITE.
  - No reads are issued for padding words.
- Latency (MEM_RD_LAT = 1, single block, L<=13, single hash): 1 + (2L + (16-L)) + 64 + 1 + 8 cycles from start to done pulse.

Decomposition:
- Package sha256_pkg holds:
  - K[0:63] constant array;
  - IV[0:7] constant array;
  - state enum;
  - functions rotr, big_sigma0/1, small_sigma0/1, ch, maj, and sha256_round(returns 256-bit working state).
- One sub-module, sha256_schedule_window:
  - 16x32 shift register;
  - ports: load (word, index), shift_new, and current Wt output.

Test Plan:
- L=0, single -> digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855 at output_addr..+7; exactly one done pulse.
- L=1, word 32'h61626364 ("abcd") -> 88d4266f d4e6338d 13b845fc f289579d 209c8978 23b9217d a3e16193 6f031589.
- L=0, double_mode=1 -> 5df6e0e2 761359d3 0a827505 8e299fcc 03815345 45f55cf4 3e41983f 5d4c9456; no extra memory reads.
- Block-boundary sweep with L=13, 14, 20, 29, 30 against a software model:
  - NB = 1, 2, 2, 2, 3 respectively;
  - repeat each at MEM_RD_LAT = 1 and 3.
- start pulsed mid-COMPUTE -> ignored, digest unchanged; reset asserted mid-COMPUTE -> outputs at reset values next edge, zero writes; a fresh start afterwards yields the correct digest.
- Write check: output_addr = 16'hFFFC -> writes at FFFC..FFFF then 0000..0003; mem_we high exactly 8 cycles per operation.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and round/sigma helper functions
// used by the stream engine and its schedule window.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_COMPUTE, ST_ADD, ST_SECOND, ST_WRITE, ST_DONE
  } state_t;

  localparam logic [31:0] IV [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  // Working state packed as {a,b,c,d,e,f,g,h}, a in the top word.
  function automatic logic [255:0] sha256_round(input logic [255:0] s, input logic [31:0] k,
                                                input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    {a, b, c, d, e, f, g, hh} = s;
    t1 = hh + big_sigma1(e) + ch(e, f, g) + k + w;
    t2 = big_sigma0(a) + maj(a, b, c);
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

endpackage

// File: rtl/sha256_schedule_window.sv
// 16-word rolling message schedule: indexed loads while fetching, whole-block
// load for the second pass, and on-the-fly expansion for rounds 16..63.
module sha256_schedule_window
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         load,
  input  logic [3:0]   load_idx,
  input  logic [31:0]  load_word,
  input  logic         block_load,
  input  logic [511:0] block_word,
  input  logic         shift_new,
  input  logic [3:0]   rd_idx,
  output logic [31:0]  wt
);

  logic [31:0] w [16];
  logic [31:0] new_word;

  // Window holds W[t-16..t-1] once expansion starts.
  assign new_word = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
  assign wt       = shift_new ? new_word : w[rd_idx];

  // NOTE: no reset on the window storage: every block rewrites all 16 words before a round reads them.
  always_ff @(posedge clk) begin
    if (block_load) begin
      for (int i = 0; i < 16; i++) w[i] <= block_word[511 - 32*i -: 32];
    end else if (load) begin
      w[load_idx] <= load_word;
    end else if (shift_new) begin
      for (int i = 0; i < 15; i++) w[i] <= w[i+1];
      w[15] <= new_word;
    end
  end

endmodule

// File: rtl/sha256_stream_engine.sv
// SHA-256 engine that streams a num_words-long message from memory, pads it on
// the fly, optionally re-hashes the digest, and writes 8 digest words back.
module sha256_stream_engine
  import sha256_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int LEN_W      = 16,
  parameter int MEM_RD_LAT = 1,
  parameter bit DOUBLE_EN  = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] message_addr,
  input  logic [ADDR_W-1:0] output_addr,
  input  logic [LEN_W-1:0]  num_words,
  input  logic              double_mode,
  output logic              busy,
  output logic              done,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  localparam int IDX_W = LEN_W + 2;
  localparam logic [255:0] IV_WORK = {IV[0], IV[1], IV[2], IV[3], IV[4], IV[5], IV[6], IV[7]};

  state_t            state;
  logic [ADDR_W-1:0] out_base;
  logic [LEN_W-1:0]  len;
  logic              dbl_pending;
  logic [IDX_W-1:0]  word_idx, total_words;
  logic [2:0]        lat_cnt, wr_k;
  logic [5:0]        round;
  logic [31:0]       h [8];
  logic [255:0]      work;

  logic [IDX_W-1:0]  len_x, next_idx;
  logic              mem_word, word_ready, last_word;
  logic [31:0]       pad_word, wt, next_h0;

  assign mem_clk    = clk;
  assign len_x      = IDX_W'(len);
  assign next_idx   = word_idx + IDX_W'(1);
  assign mem_word   = word_idx < len_x;
  assign word_ready = !mem_word || (lat_cnt == 3'(MEM_RD_LAT));
  assign last_word  = word_idx[3:0] == 4'hf;
  assign next_h0    = h[0] + work[255:224];

  // NOTE: default assigned first so every path drives pad_word and no latch is inferred.
  always_comb begin
    pad_word = '0;
    if (word_idx == len_x)                     pad_word = 32'h8000_0000;
    else if (word_idx == total_words - IDX_W'(1)) pad_word = 32'({len, 5'b0});
  end

  sha256_schedule_window u_window (
    .clk        (clk),
    .load       (state == ST_FETCH && word_ready),
    .load_idx   (word_idx[3:0]),
    .load_word  (mem_word ? mem_read_data : pad_word),
    .block_load (state == ST_SECOND),
    .block_word ({h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7], 32'h8000_0000, 192'd0, 32'd256}),
    .shift_new  (state == ST_COMPUTE && round[5:4] != 2'b00),
    .rd_idx     (round[3:0]),
    .wt         (wt)
  );

  // NOTE: all sequential state uses <= so each branch sees pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      busy           <= 1'b0;
      done           <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      out_base       <= '0;
      len            <= '0;
      dbl_pending    <= 1'b0;
      word_idx       <= '0;
      total_words    <= '0;
      lat_cnt        <= '0;
      round          <= '0;
      wr_k           <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: if (start) begin
          state       <= ST_FETCH;
          busy        <= 1'b1;
          out_base    <= output_addr;
          len         <= num_words;
          dbl_pending <= DOUBLE_EN && double_mode;
          // 16 * ((L+2)/16 + 1)
          total_words <= ((IDX_W'(num_words) + IDX_W'(2)) & ~IDX_W'(15)) + IDX_W'(16);
          word_idx    <= '0;
          lat_cnt     <= '0;
          mem_addr    <= message_addr;
        end
        ST_FETCH: begin
          if (!word_ready) begin
            lat_cnt <= lat_cnt + 3'd1;
          end else begin
            lat_cnt  <= '0;
            word_idx <= next_idx;
            if (next_idx < len_x) mem_addr <= mem_addr + ADDR_W'(1);
            if (last_word) state <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          round <= round + 6'd1;
          if (round == 6'd63) state <= ST_ADD;
        end
        ST_ADD: begin
          if (word_idx != total_words) begin
            state <= ST_FETCH;
          end else if (dbl_pending) begin
            dbl_pending <= 1'b0;
            state       <= ST_SECOND;
          end else begin
            state          <= ST_WRITE;
            mem_we         <= 1'b1;
            mem_addr       <= out_base;
            mem_write_data <= next_h0;
            wr_k           <= '0;
          end
        end
        ST_SECOND: state <= ST_COMPUTE;
        ST_WRITE: begin
          if (wr_k == 3'd7) begin
            state  <= ST_DONE;
            mem_we <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            wr_k           <= wr_k + 3'd1;
            mem_addr       <= mem_addr + ADDR_W'(1);
            mem_write_data <= h[wr_k + 3'd1];
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Hash and working registers are reloaded at the start of every pass.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) h <= IV;
    if (state == ST_FETCH && word_ready && last_word)
      work <= {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    if (state == ST_COMPUTE) work <= sha256_round(work, K[round], wt);
    if (state == ST_ADD) begin
      for (int i = 0; i < 8; i++) h[i] <= h[i] + work[255 - 32*i -: 32];
    end
    if (state == ST_SECOND) begin
      h    <= IV;
      work <= IV_WORK;
    end
  end

endmodule

// File: tb/tb_sha256_stream_engine.sv
// Scoreboard bench for sha256_stream_engine: two instances (read latency 1 and 3)
// checked against a queue-based SHA-256 reference model.
module tb_sha256_stream_engine;
  import sha256_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start_a, start_b, double_mode;
  logic [15:0] message_addr, output_addr, num_words;
  logic        busy_a, done_a, mclk_a, we_a, busy_b, done_b, mclk_b, we_b;
  logic [15:0] addr_a, addr_b;
  logic [31:0] wdata_a, rdata_a, wdata_b, rdata_b;

  logic [31:0] mem_a [65536];
  logic [31:0] mem_b [65536];
  logic [31:0] pipe_b [3];
  logic [47:0] exp_a [$];
  logic [47:0] exp_b [$];
  logic [47:0] e_a, e_b;
  logic [31:0] cur_msg [$];
  int n_checks = 0, n_fail = 0, wcnt_a = 0, wcnt_b = 0;
  logic prev_done_a = 1'b0, prev_done_b = 1'b0;

  sha256_stream_engine #(.MEM_RD_LAT(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .message_addr(message_addr),
    .output_addr(output_addr), .num_words(num_words), .double_mode(double_mode),
    .busy(busy_a), .done(done_a), .mem_clk(mclk_a), .mem_we(we_a), .mem_addr(addr_a),
    .mem_write_data(wdata_a), .mem_read_data(rdata_a));

  sha256_stream_engine #(.MEM_RD_LAT(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .message_addr(message_addr),
    .output_addr(output_addr), .num_words(num_words), .double_mode(double_mode),
    .busy(busy_b), .done(done_b), .mem_clk(mclk_b), .mem_we(we_b), .mem_addr(addr_b),
    .mem_write_data(wdata_b), .mem_read_data(rdata_b));

  // Read-only memory models with 1 and 3 cycles of read latency.
  always @(posedge clk) begin
    rdata_a   <= mem_a[addr_a];
    pipe_b[0] <= mem_b[addr_b];
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign rdata_b = pipe_b[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic record_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Monitors: every digest write is popped from the expectation queue.
  always @(negedge clk) begin
    if (we_a) begin
      wcnt_a++;
      if (exp_a.size() == 0) record_fail("write_a unexpected");
      else begin
        e_a = exp_a.pop_front();
        check("write_a addr/data", {16'h0, addr_a, wdata_a}, {16'h0, e_a});
      end
    end
    if (done_a) begin
      check("writes_per_op_a", 64'(wcnt_a), 64'd8);
      check("done_single_pulse_a", 64'(prev_done_a), 64'd0);
      wcnt_a = 0;
    end
    prev_done_a = done_a;
  end

  always @(negedge clk) begin
    if (we_b) begin
      wcnt_b++;
      if (exp_b.size() == 0) record_fail("write_b unexpected");
      else begin
        e_b = exp_b.pop_front();
        check("write_b addr/data", {16'h0, addr_b, wdata_b}, {16'h0, e_b});
      end
    end
    if (done_b) begin
      check("writes_per_op_b", 64'(wcnt_b), 64'd8);
      check("done_single_pulse_b", 64'(prev_done_b), 64'd0);
      wcnt_b = 0;
    end
    prev_done_b = done_b;
  end

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference SHA-256 over a word message: standard padding, full 64-word W array.
  function automatic logic [255:0] sha_ref(input logic [31:0] msg [$]);
    logic [31:0] p [$];
    logic [31:0] hv [8];
    logic [31:0] v [8];
    logic [31:0] w [64];
    logic [31:0] t1, t2;
    p = msg;
    p.push_back(32'h8000_0000);
    while (p.size() % 16 != 14) p.push_back(32'h0);
    p.push_back(32'h0);
    p.push_back(32'(msg.size()) * 32'd32);
    for (int i = 0; i < 8; i++) hv[i] = IV[i];
    for (int b = 0; b < p.size() / 16; b++) begin
      for (int t = 0; t < 64; t++) begin
        if (t < 16) w[t] = p[16*b + t];
        else w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                  + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      end
      v = hv;
      for (int t = 0; t < 64; t++) begin
        t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6]))
           + K[t] + w[t];
        t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
        v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
        v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) hv[i] = hv[i] + v[i];
    end
    return {hv[0], hv[1], hv[2], hv[3], hv[4], hv[5], hv[6], hv[7]};
  endfunction

  function automatic logic [255:0] model(input logic [31:0] msg [$], input bit dbl);
    logic [255:0] d;
    logic [31:0] m2 [$];
    d = sha_ref(msg);
    if (dbl) begin
      for (int k = 0; k < 8; k++) m2.push_back(d[255 - 32*k -: 32]);
      d = sha_ref(m2);
    end
    return d;
  endfunction

  task automatic make_msg(input int l);
    cur_msg = {};
    for (int i = 0; i < l; i++) cur_msg.push_back($urandom);
  endtask

  // Loads the message, queues the 8 expected writes, pulses start; returns on the cycle after start.
  task automatic issue_op(input bit b, input logic [15:0] maddr, input logic [15:0] oaddr,
                          input bit dbl, input logic [255:0] dig, input bit expect_writes);
    logic [15:0] ad;
    for (int i = 0; i < cur_msg.size(); i++) begin
      ad = maddr + 16'(i);
      if (b) mem_b[ad] = cur_msg[i];
      else   mem_a[ad] = cur_msg[i];
    end
    if (expect_writes) begin
      for (int k = 0; k < 8; k++) begin
        if (b) exp_b.push_back({16'(oaddr + 16'(k)), dig[255 - 32*k -: 32]});
        else   exp_a.push_back({16'(oaddr + 16'(k)), dig[255 - 32*k -: 32]});
      end
    end
    @(negedge clk);
    message_addr = maddr;
    output_addr  = oaddr;
    num_words    = 16'(cur_msg.size());
    double_mode  = dbl;
    if (b) start_b = 1'b1;
    else   start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    check(b ? "busy_after_start_b" : "busy_after_start_a", 64'(b ? busy_b : busy_a), 64'd1);
  endtask

  // exp_lat > 0 checks cycles from the start cycle to the done pulse.
  task automatic wait_done(input bit b, input string name, input int exp_lat);
    int cyc;
    cyc = 1;
    while (!(b ? done_b : done_a) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (!(b ? done_b : done_a)) record_fail({name, " timeout waiting for done"});
    else if (exp_lat > 0) check({name, " latency"}, 64'(cyc), 64'(exp_lat));
    @(negedge clk);
    check({name, " pending writes"}, 64'(b ? exp_b.size() : exp_a.size()), 64'd0);
  endtask

  initial begin
    int sweep [5];
    int l;
    bit dbl;
    logic [255:0] d;
    sweep = '{13, 14, 20, 29, 30};
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    message_addr = '0; output_addr = '0; num_words = '0; double_mode = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs_a", {13'h0, busy_a, done_a, we_a, addr_a, wdata_a}, 64'h0);
    check("reset_outputs_b", {13'h0, busy_b, done_b, we_b, addr_b, wdata_b}, 64'h0);
    reset = 1'b0;
    @(negedge clk);

    // Known-answer vectors.
    make_msg(0);
    issue_op(0, 16'h0100, 16'h2000, 1'b0,
             256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, 1'b1);
    wait_done(0, "empty", 90);
    cur_msg = {32'h61626364};
    issue_op(0, 16'h0200, 16'h2010, 1'b0,
             256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589, 1'b1);
    wait_done(0, "abcd", 91);
    make_msg(0);
    issue_op(0, 16'h0300, 16'h2020, 1'b1,
             256'h5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456, 1'b1);
    wait_done(0, "empty_double_a", 0);
    issue_op(1, 16'h0300, 16'h2020, 1'b1,
             256'h5df6e0e2761359d30a8275058e299fcc0381534545f55cf43e41983f5d4c9456, 1'b1);
    wait_done(1, "empty_double_b", 0);

    // Block-boundary sweep on both read latencies.
    foreach (sweep[s]) begin
      for (int b = 0; b < 2; b++) begin
        make_msg(sweep[s]);
        d = model(cur_msg, 1'b0);
        issue_op(b[0], 16'($urandom), 16'($urandom), 1'b0, d, 1'b1);
        wait_done(b[0], "sweep", (b == 0 && sweep[s] == 13) ? 103 : 0);
      end
    end

    // Randomized lengths, addresses and hash mode.
    for (int r = 0; r < 8; r++) begin
      l   = int'($urandom_range(0, 45));
      dbl = 1'($urandom);
      make_msg(l);
      d = model(cur_msg, dbl);
      issue_op(r[0], 16'($urandom), 16'($urandom), dbl, d, 1'b1);
      wait_done(r[0], "random", 0);
    end

    // A start pulse during COMPUTE must be ignored.
    make_msg(5);
    d = model(cur_msg, 1'b0);
    issue_op(0, 16'h4000, 16'h5000, 1'b0, d, 1'b1);
    repeat (30) @(negedge clk);
    message_addr = 16'h6000; output_addr = 16'h7777; num_words = 16'd3; double_mode = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done(0, "start_ignored", 0);

    // Reset mid-COMPUTE aborts with no writes.
    make_msg(5);
    issue_op(0, 16'h4100, 16'h5100, 1'b0, '0, 1'b0);
    repeat (30) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("reset_mid_compute_outputs", {13'h0, busy_a, done_a, we_a, addr_a, wdata_a}, 64'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (150) @(negedge clk);
    check("idle_after_reset", {62'h0, busy_a, done_a}, 64'h0);

    // Fresh start after reset, with digest addresses wrapping past 16'hFFFF.
    make_msg(7);
    d = model(cur_msg, 1'b0);
    issue_op(0, 16'h0500, 16'hFFFC, 1'b0, d, 1'b1);
    wait_done(0, "wrap_after_reset", 97);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
